// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight loading, data streaming and pipeline drain for an N x N systolic MAC array.
// Handshake and step outputs are decoded from the registered state and the current-cycle inputs.
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             keep_w_i,
    input  logic             halt_i,
    input  logic             w_valid_i,
    output logic             w_ready_o,
    output logic [N-1:0]     wr_weight_v_o,
    input  logic             d_valid_i,
    output logic             d_ready_o,
    output logic             step_o,
    output logic             flush_o,
    output logic             res_valid_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int RW = $clog2(N);
    localparam int KW = $clog2((1 << LEN_W) + 2 * N);

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] data_cnt_q, data_cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic             w_acc;
    logic             last_k;

    always_comb begin
        w_ready_o     = (state_q == LOAD_W) && !halt_i;
        w_acc         = w_ready_o && w_valid_i;
        wr_weight_v_o = w_acc ? N'(1) << row_cnt_q : '0;
        // a zero-length job never accepts data, so no step can leak out of COMPUTE
        d_ready_o     = (state_q == COMPUTE) && !halt_i && (len_q != '0);
        flush_o       = (state_q == DRAIN);
        step_o        = (d_ready_o && d_valid_i) || (flush_o && !halt_i);
        last_k        = k_q == KW'(len_q) + KW'(2 * N - 2);
        res_valid_o   = step_o && (k_q >= KW'(2 * N - 1)) && (k_q <= KW'(len_q) + KW'(2 * N - 2));
        busy_o        = (state_q != IDLE);
        done_o        = (state_q == DONE);
        state_d       = state_q;
        len_d         = len_q;
        row_cnt_d     = w_acc ? row_cnt_q + RW'(1) : row_cnt_q;
        data_cnt_d    = (state_q == COMPUTE && step_o) ? data_cnt_q + LEN_W'(1) : data_cnt_q;
        k_d           = step_o ? k_q + KW'(1) : k_q;
        case (state_q)
            IDLE: if (start_i && !halt_i) begin
                state_d    = keep_w_i ? COMPUTE : LOAD_W;
                len_d      = len_i;
                row_cnt_d  = '0;
                data_cnt_d = '0;
                k_d        = '0;
            end
            LOAD_W:  if (w_acc && row_cnt_q == RW'(N - 1)) state_d = COMPUTE;
            COMPUTE: if (len_q == '0 && !halt_i) state_d = DONE;
                     else if (step_o && data_cnt_q + LEN_W'(1) == len_q) state_d = DRAIN;
            DRAIN:   if (step_o && last_k) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            len_q      <= '0;
            data_cnt_q <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            len_q      <= len_d;
            data_cnt_q <= data_cnt_d;
            k_q        <= k_d;
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed jobs on an N=4 controller; a negedge monitor tallies steps, results and weight writes.
module tb_systolic_ctrl;
    localparam int N = 4;
    localparam int LEN_W = 8;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             start_i = 0;
    logic [LEN_W-1:0] len_i = '0;
    logic             keep_w_i = 0;
    logic             halt_i = 0;
    logic             w_valid_i = 1;
    logic             w_ready_o;
    logic [N-1:0]     wr_weight_v_o;
    logic             d_valid_i = 1;
    logic             d_ready_o;
    logic             step_o;
    logic             flush_o;
    logic             res_valid_o;
    logic             busy_o;
    logic             done_o;

    systolic_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i), .keep_w_i(keep_w_i),
        .halt_i(halt_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .wr_weight_v_o(wr_weight_v_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .step_o(step_o), .flush_o(flush_o),
        .res_valid_o(res_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0, steps, res_cnt, flush_steps, w_cnt, dones, bad, halt_cyc;
    int first_w, last_w, last_step, done_cyc;
    logic [63:0] res_mask, wv_log;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        steps = 0; res_cnt = 0; flush_steps = 0; w_cnt = 0; dones = 0; bad = 0; halt_cyc = 0;
        first_w = 0; last_w = 0; last_step = 0; done_cyc = 0; res_mask = '0; wv_log = '0;
    endtask

    always @(negedge clk) if (rst_n) begin
        cyc++;
        if (step_o) begin
            if (res_valid_o) begin
                res_mask[steps] = 1'b1;
                res_cnt++;
            end
            if (flush_o) flush_steps++;
            if (!flush_o && !d_valid_i) bad++;
            last_step = cyc;
            steps++;
        end
        if (halt_i && (step_o || res_valid_o || wr_weight_v_o != '0)) bad++;
        if (res_valid_o && !step_o) bad++;
        if (wr_weight_v_o != '0) begin
            wv_log = {wv_log[59:0], wr_weight_v_o};
            w_cnt++;
            if (w_cnt == 1) first_w = cyc;
            last_w = cyc;
        end
        if (halt_i && flush_o) halt_cyc++;
        if (done_o) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic kick(input int len, input bit keep);
        clr();
        start_i = 1; len_i = LEN_W'(len); keep_w_i = keep;
        @(posedge clk) #1;
        start_i = 0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (dones == 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({tag, "_done"}, dones, 1);
    endtask

    task automatic check_full(input string tag);
        chk({tag, "_steps"}, steps, 10);
        chk({tag, "_res"}, res_cnt, 3);
        chk({tag, "_mask"}, res_mask, 64'h380);
        chk({tag, "_flush"}, flush_steps, 7);
        chk({tag, "_wlog"}, wv_log, 64'h1248);
        chk({tag, "_wconsec"}, last_w - first_w, 3);
        chk({tag, "_done_lat"}, done_cyc - last_step, 1);
        chk({tag, "_bad"}, bad, 0);
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        clr();
        #12;
        chk("rst_outs", {w_ready_o, wr_weight_v_o, d_ready_o, step_o, flush_o, res_valid_o, busy_o, done_o}, '0);
        rst_n = 1;
        @(posedge clk) #1;
        chk("idle_busy", busy_o, 0);

        kick(3, 0);
        chk("t1_busy", busy_o, 1);
        wait_done("t1");
        check_full("t1");

        kick(2, 1);
        wait_done("t2");
        chk("t2_w", w_cnt, 0);
        chk("t2_steps", steps, 9);
        chk("t2_mask", res_mask, 64'h180);
        chk("t2_res", res_cnt, 2);

        kick(0, 0);
        wait_done("t3");
        chk("t3_w", w_cnt, 4);
        chk("t3_steps", steps, 0);
        chk("t3_res", res_cnt, 0);
        chk("t3_bad", bad, 0);

        kick(3, 0);
        for (int t = 0; t < 100 && flush_steps < 2; t++) @(posedge clk);
        #1 halt_i = 1;
        repeat (5) @(posedge clk);
        #1 halt_i = 0;
        chk("t4_halt_cyc", halt_cyc, 5);
        wait_done("t4");
        chk("t4_steps", steps, 10);
        chk("t4_res", res_cnt, 3);
        chk("t4_mask", res_mask, 64'h380);
        chk("t4_bad", bad, 0);

        d_valid_i = 1;
        kick(3, 1);
        for (int i = 0; i < 200 && dones == 0; i++) begin
            d_valid_i = ~d_valid_i;
            start_i = (i == 3);
            @(posedge clk) #1;
        end
        start_i = 0;
        d_valid_i = 1;
        chk("t5_done", dones, 1);
        chk("t5_steps", steps, 10);
        chk("t5_data_steps", steps - flush_steps, 3);
        chk("t5_bad", bad, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_queue", busy_o, 0);
        chk("t5_dones", dones, 1);

        d_valid_i = 0;
        kick(5, 1);
        d_valid_i = 1;
        @(posedge clk) #1;
        d_valid_i = 0;
        @(posedge clk) #1;
        chk("t6_pre_steps", steps, 1);
        chk("t6_pre_busy", busy_o, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_outs", {w_ready_o, wr_weight_v_o, d_ready_o, step_o, flush_o, res_valid_o, busy_o, done_o}, '0);
        @(posedge clk) #1;
        rst_n = 1;
        d_valid_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_no_resume", busy_o, 0);
        kick(3, 0);
        wait_done("t6");
        check_full("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4, SHALL set the array dimension (N rows x N columns of MAC units), N >= 2.
REQ-002 Parameter LEN_W, default 8, SHALL set the width of the job-length field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start_i  input  1  SHALL request a new job; sampled only in IDLE.
REQ-006 len_i  input  LEN_W  SHALL give the data-vector count of the job; latched when start_i is accepted.
REQ-007 keep_w_i  input  1  SHALL skip weight loading when high at start acceptance.
REQ-008 halt_i  input  1  SHALL freeze the controller (JTAG inspection stall).
REQ-009 w_valid_i / w_ready_o  input / output  1 / 1  SHALL be the weight-row handshake.
REQ-010 wr_weight_v_o  output  N  SHALL be the one-hot per-row weight write enable.
REQ-011 d_valid_i / d_ready_o  input / output  1 / 1  SHALL be the data-vector handshake.
REQ-012 step_o  output  1  SHALL be the array-wide step enable.
REQ-013 flush_o  output  1  SHALL tell the feeder to drive zero data into the array.
REQ-014 res_valid_o  output  1  SHALL mark the bottom-row outputs as valid at this step edge.
REQ-015 busy_o / done_o  output / output  1 / 1  SHALL flag job in progress / one-cycle job-complete pulse.

Function
REQ-016 States SHALL be IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
REQ-017 IDLE: start_i=1 -> LOAD_W if keep_w_i=0, else COMPUTE; len_i and keep_w_i are latched on the same edge.
REQ-018 LOAD_W: w_ready_o = !halt_i; on w_valid_i & w_ready_o, wr_weight_v_o SHALL equal one-hot(row_cnt) in that same cycle, and row_cnt SHALL increment; after the N-th accept -> COMPUTE.
REQ-019 wr_weight_v_o SHALL be all-zero in every cycle without a weight accept.
REQ-020 COMPUTE: d_ready_o = !halt_i; step_o = d_valid_i & d_ready_o; each step increments data_cnt; after the len-th step -> DRAIN.
REQ-021 len == 0 SHALL take the transition COMPUTE -> DONE immediately, with zero steps, no DRAIN and no res_valid_o.
REQ-022 DRAIN: step_o = !halt_i and flush_o = 1; after exactly 2N-1 steps -> DONE.
REQ-023 A job-wide step index k (0-based, counting only step_o cycles) SHALL be kept; res_valid_o = step_o & (k >= 2N-1) & (k <= len+2N-2).
REQ-024 Total steps per job SHALL be len+2N-1 (len > 0), and res_valid_o SHALL assert exactly len times.
REQ-025 DONE: done_o = 1 for one cycle, then -> IDLE.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 halt_i=1 SHALL force step_o, w_ready_o, d_ready_o, wr_weight_v_o and res_valid_o to 0, and SHALL hold state and all counters.
REQ-028 halt_i SHALL NOT delay the done_o pulse once in DONE.
REQ-029 start_i outside IDLE SHALL be ignored, with no queuing.
REQ-030 k SHALL be at least clog2(2^LEN_W + 2N) bits wide, so no counter wraps within a legal job.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, clear all counters and latched fields, and drive every output to 0, including mid-job.
REQ-032 After rst_n deasserts, a job SHALL start only on a new start_i; no partial job resumes.

Verification (N=4)
REQ-033 start, len=3, keep_w=0, valids always high -> wr_weight_v_o 0001, 0010, 0100, 1000 on consecutive cycles; 3 COMPUTE steps; 7 DRAIN steps with flush_o=1; res_valid_o on step indices 7, 8, 9; done_o one cycle after step 9.
REQ-034 keep_w=1, len=2 -> no wr_weight_v_o activity; 9 steps total; res_valid_o on indices 7 and 8.
REQ-035 len=0 -> LOAD_W completes, no step_o, no res_valid_o, done_o pulses.
REQ-036 halt_i high for 5 cycles mid-DRAIN -> step_o low for those 5 cycles, then resumes; total step count and res_valid_o count are unchanged.
REQ-037 d_valid_i toggling 1,0,1,0 in COMPUTE -> step_o mirrors the accepted beats only; start_i pulsed while busy is ignored.
REQ-038 rst_n low during COMPUTE after 1 step -> all outputs 0 at once; next start runs a full, correct job.
